// File: rtl/chunked_addsub_if.sv
// chunked_addsub_if: operand and result handshake bundle for chunked_addsub.
//   Operand side : in_valid, in_ready, inp1, inp2, sub
//   Result side  : out_valid, out_ready, out, c31, c32, ovf (+ zero)
//   master modport drives operands and accepts results; slave is the adder.
//   Optional macro CHUNKED_ADDER_ZERO_EN adds the registered zero flag.
interface chunked_addsub_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] inp1;
    logic [WIDTH-1:0] inp2;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             c31;
    logic             c32;
    logic             ovf;
`ifdef CHUNKED_ADDER_ZERO_EN
    logic             zero;
`endif

    modport master (
        output in_valid, inp1, inp2, sub, out_ready,
        input  in_ready, out_valid, out, c31, c32, ovf
`ifdef CHUNKED_ADDER_ZERO_EN
        , input zero
`endif
    );

    modport slave (
        input  in_valid, inp1, inp2, sub, out_ready,
        output in_ready, out_valid, out, c31, c32, ovf
`ifdef CHUNKED_ADDER_ZERO_EN
        , output zero
`endif
    );
endinterface

// File: rtl/chunked_addsub.sv
// chunked_addsub: multi-cycle adder/subtractor, CHUNK bits per clock with a
// registered carry between chunks.
//   clk  : rising-edge clock
//   rst  : synchronous active-low reset
//   bus  : chunked_addsub_if.slave (operand handshake in, result handshake out)
// Optional macro CHUNKED_ADDER_ZERO_EN adds the zero flag, built by
// OR-accumulating each chunk result while busy.
module chunked_addsub #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    chunked_addsub_if.slave  bus
);
    localparam int unsigned NCH = WIDTH / CHUNK;
    localparam int unsigned KW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic [WIDTH-1:0] res_d;
    logic             carry_q;
    logic [KW-1:0]    k_q;
    logic             in_ready_q, out_valid_q;
    logic             c31_q, c32_q, ovf_q;
    logic             last;

    logic [CHUNK-1:0] ca, cb;
    logic [CHUNK:0]   csum;
    logic             cmsb;

    // Operands shift right one chunk per cycle so the active chunk is always
    // the low CHUNK bits; results enter from the top, so after NCH cycles
    // chunk k sits at res[k*CHUNK +: CHUNK].
    always_comb begin
        ca   = a_q[CHUNK-1:0];
        cb   = b_q[CHUNK-1:0];
        csum = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, carry_q};
        last = (k_q == KW'(NCH - 1));
        res_d = WIDTH'({csum[CHUNK-1:0], res_q} >> CHUNK);
    end

    // Carry into the top bit of the current chunk; only meaningful on the
    // final chunk, which holds bit WIDTH-1.
    generate
        if (CHUNK == 1) begin : g_cmsb_1
            assign cmsb = carry_q;
        end else begin : g_cmsb_n
            logic [CHUNK-1:0] lo;
            assign lo   = {1'b0, ca[CHUNK-2:0]} + {1'b0, cb[CHUNK-2:0]}
                        + {{(CHUNK-1){1'b0}}, carry_q};
            assign cmsb = lo[CHUNK-1];
        end
    endgenerate

`ifdef CHUNKED_ADDER_ZERO_EN
    logic nz_q, zero_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            k_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            c31_q       <= 1'b0;
            c32_q       <= 1'b0;
            ovf_q       <= 1'b0;
`ifdef CHUNKED_ADDER_ZERO_EN
            nz_q        <= 1'b0;
            zero_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.inp1;
                        b_q        <= bus.sub ? ~bus.inp2 : bus.inp2;
                        carry_q    <= bus.sub;
                        k_q        <= '0;
                        in_ready_q <= 1'b0;
`ifdef CHUNKED_ADDER_ZERO_EN
                        nz_q       <= 1'b0;
`endif
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    a_q     <= a_q >> CHUNK;
                    b_q     <= b_q >> CHUNK;
                    carry_q <= csum[CHUNK];
                    res_q   <= res_d;
`ifdef CHUNKED_ADDER_ZERO_EN
                    nz_q    <= nz_q | (|csum[CHUNK-1:0]);
`endif
                    if (last) begin
                        k_q         <= '0;
                        c31_q       <= cmsb;
                        c32_q       <= csum[CHUNK];
                        ovf_q       <= cmsb ^ csum[CHUNK];
`ifdef CHUNKED_ADDER_ZERO_EN
                        zero_q      <= ~(nz_q | (|csum[CHUNK-1:0]));
`endif
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out       = res_q;
    assign bus.c31       = c31_q;
    assign bus.c32       = c32_q;
    assign bus.ovf       = ovf_q;
`ifdef CHUNKED_ADDER_ZERO_EN
    assign bus.zero      = zero_q;
`endif
endmodule

// File: tb/tb_chunked_addsub.sv
// Scoreboard bench for chunked_addsub: a CHUNK=8 and a CHUNK=32 instance.
module tb_chunked_addsub;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    chunked_addsub_if #(.WIDTH(32)) b8 ();
    chunked_addsub_if #(.WIDTH(32)) b32 ();

    chunked_addsub #(.WIDTH(32), .CHUNK(8))  u8  (.clk(clk), .rst(rst), .bus(b8));
    chunked_addsub #(.WIDTH(32), .CHUNK(32)) u32 (.clk(clk), .rst(rst), .bus(b32));

    typedef struct {
        logic [31:0] out;
        logic        c31;
        logic        c32;
        logic        ovf;
        logic        zero;
    } exp_t;

    exp_t q8[$];
    exp_t q32[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic compare(input string tag, input exp_t e, input logic [31:0] o,
                           input logic c31, input logic c32, input logic ovf,
                           input logic zero);
        chk({tag, ".out"}, o, e.out);
        chk({tag, ".c31"}, 32'(c31), 32'(e.c31));
        chk({tag, ".c32"}, 32'(c32), 32'(e.c32));
        chk({tag, ".ovf"}, 32'(ovf), 32'(e.ovf));
`ifdef CHUNKED_ADDER_ZERO_EN
        chk({tag, ".zero"}, 32'(zero), 32'(e.zero));
`endif
    endtask

    // Monitors: pop one expectation per completed result handshake.
    always @(negedge clk) begin
        if (b8.out_valid && b8.out_ready) begin
            if (q8.size() == 0) begin
                chk("unexpected_result8", 32'(1), 32'(0));
            end else begin
                exp_t e;
                logic z;
                e = q8.pop_front();
                z = 1'b0;
`ifdef CHUNKED_ADDER_ZERO_EN
                z = b8.zero;
`endif
                compare("res8", e, b8.out, b8.c31, b8.c32, b8.ovf, z);
            end
        end
    end

    always @(negedge clk) begin
        if (b32.out_valid && b32.out_ready) begin
            if (q32.size() == 0) begin
                chk("unexpected_result32", 32'(1), 32'(0));
            end else begin
                exp_t e;
                logic z;
                e = q32.pop_front();
                z = 1'b0;
`ifdef CHUNKED_ADDER_ZERO_EN
                z = b32.zero;
`endif
                compare("res32", e, b32.out, b32.c31, b32.c32, b32.ovf, z);
            end
        end
    end

    // Present operands, wait (bounded) for acceptance, then scramble inputs
    // so any late sampling would corrupt the result.
    task automatic send(input bit w, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input exp_t e, input bit push);
        int  n;
        logic rdy;
        n = 0;
        if (w) begin b32.inp1 = a; b32.inp2 = b; b32.sub = s; b32.in_valid = 1'b1; end
        else   begin b8.inp1  = a; b8.inp2  = b; b8.sub  = s; b8.in_valid  = 1'b1; end
        do begin
            @(negedge clk);
            n++;
            rdy = w ? b32.in_ready : b8.in_ready;
        end while (!rdy && n < 50);
        if (!rdy) chk("accept_timeout", 32'(0), 32'(1));
        if (push) begin
            if (w) q32.push_back(e); else q8.push_back(e);
        end
        @(posedge clk);
        #1;
        if (w) begin b32.in_valid = 1'b0; b32.inp1 = ~a; b32.inp2 = 32'h5A5A5A5A; b32.sub = ~s; end
        else   begin b8.in_valid  = 1'b0; b8.inp1  = ~a; b8.inp2  = 32'h5A5A5A5A; b8.sub  = ~s; end
    endtask

    // Called right after the accept edge: count negedges until out_valid.
    task automatic wait_done(input bit w, input int lat, input string nm);
        int n;
        logic v;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            v = w ? b32.out_valid : b8.out_valid;
        end while (!v && n < 40);
        chk(nm, 32'(n), 32'(lat));
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input logic [31:0] o, input logic c31, input logic c32,
                                input logic ovf, input logic zero);
        exp_t e;
        e.out = o; e.c31 = c31; e.c32 = c32; e.ovf = ovf; e.zero = zero;
        return e;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic seen;
        b8.in_valid = 1'b0;  b8.inp1 = '0;  b8.inp2 = '0;  b8.sub = 1'b0;  b8.out_ready = 1'b1;
        b32.in_valid = 1'b0; b32.inp1 = '0; b32.inp2 = '0; b32.sub = 1'b0; b32.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.out", b8.out, 32'h0);
        chk("rst.out_valid", 32'(b8.out_valid), 32'(0));
        chk("rst.flags", {29'd0, b8.c31, b8.c32, b8.ovf}, 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("rst.in_ready8", 32'(b8.in_ready), 32'(1));
        chk("rst.in_ready32", 32'(b32.in_ready), 32'(1));
        @(posedge clk); #1;

        // CHUNK=8 directed vectors, latency NCH edges -> 5th negedge after accept
        send(0, 32'hFFFFFFFF, 32'h00000001, 1'b0, mk(32'h00000000, 1, 1, 0, 1), 1);
        wait_done(0, 5, "lat8");
        send(0, 32'h7FFFFFFF, 32'h00000001, 1'b0, mk(32'h80000000, 1, 0, 1, 0), 1);
        wait_done(0, 5, "lat8b");
        send(0, 32'h00000005, 32'h00000007, 1'b1, mk(32'hFFFFFFFE, 0, 0, 0, 0), 1);
        wait_done(0, 5, "lat8c");
        send(0, 32'h80000000, 32'h00000001, 1'b1, mk(32'h7FFFFFFF, 0, 1, 1, 0), 1);
        wait_done(0, 5, "lat8d");
        send(0, 32'h00001234, 32'h00001234, 1'b1, mk(32'h00000000, 1, 1, 0, 1), 1);
        wait_done(0, 5, "lat8e");
        send(0, 32'h000000FF, 32'h00000001, 1'b0, mk(32'h00000100, 0, 0, 0, 0), 1);
        wait_done(0, 5, "lat8f");

        // CHUNK=32 instance: single BUSY cycle
        send(1, 32'h12345678, 32'h11111111, 1'b0, mk(32'h23456789, 0, 0, 0, 0), 1);
        wait_done(1, 2, "lat32");
        send(1, 32'hFFFFFFFF, 32'h00000001, 1'b0, mk(32'h00000000, 1, 1, 0, 1), 1);
        wait_done(1, 2, "lat32b");
        send(1, 32'h7FFFFFFF, 32'h00000001, 1'b0, mk(32'h80000000, 1, 0, 1, 0), 1);
        wait_done(1, 2, "lat32c");

        // Backpressure: result held, new operands refused until released
        b8.out_ready = 1'b0;
        send(0, 32'h00000003, 32'h00000004, 1'b0, mk(32'h00000007, 0, 0, 0, 0), 1);
        n = 0;
        do begin @(negedge clk); n++; end while (!b8.out_valid && n < 40);
        chk("bp.valid_rise", 32'(b8.out_valid), 32'(1));
        @(posedge clk); #1;
        b8.inp1 = 32'hFFFF0000; b8.inp2 = 32'h00010000; b8.sub = 1'b0; b8.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp.out_held", b8.out, 32'h00000007);
            chk("bp.valid_held", 32'(b8.out_valid), 32'(1));
            chk("bp.in_ready_low", 32'(b8.in_ready), 32'(0));
        end
        q8.push_back(mk(32'h00000000, 1, 1, 0, 1));
        @(posedge clk); #1 b8.out_ready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!b8.in_ready && n < 40);
        chk("bp.reaccept_cycles", 32'(n), 32'(2));
        @(posedge clk); #1 b8.in_valid = 1'b0;
        wait_done(0, 5, "bp.lat");

        // Reset two cycles into BUSY aborts the operation
        send(0, 32'h11111111, 32'h22222222, 1'b0, mk(32'h33333333, 0, 0, 0, 0), 0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("abort.out", b8.out, 32'h0);
        chk("abort.flags", {29'd0, b8.c31, b8.c32, b8.ovf}, 32'd0);
`ifdef CHUNKED_ADDER_ZERO_EN
        chk("abort.zero", 32'(b8.zero), 32'(0));
`endif
        chk("abort.in_ready", 32'(b8.in_ready), 32'(1));
        seen = b8.out_valid;
        repeat (8) begin @(negedge clk); seen = seen | b8.out_valid; end
        chk("abort.no_valid", 32'(seen), 32'(0));

        // Recovery after abort
        @(posedge clk); #1;
        send(0, 32'h0F0F0F0F, 32'h01010101, 1'b0, mk(32'h10101010, 0, 0, 0, 0), 1);
        wait_done(0, 5, "recover.lat");

        repeat (3) @(negedge clk);
        chk("drain8", 32'(q8.size()), 32'(0));
        chk("drain32", 32'(q32.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
